// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR coefficient loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fir_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 6;
  localparam int WINLEN_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_smp_gate.sv
// Sample-stream gate: passes samples through unless a reload blocks them.
// Latency: zero cycles, purely combinational.
// Backpressure: downstream busy forwarded upstream; while blocked, upstream sees busy=1.
module fir_smp_gate #(
  parameter int DWIDTH = 8
) (
  input  logic              block,
  input  logic              in_valid,
  output logic              in_busy,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_busy,
  output logic [DWIDTH-1:0] out_data
);

  // Data is left flowing; only the handshake is gated, so nothing transfers while blocked.
  always_comb begin
    out_valid = in_valid & ~block;
    out_data  = in_data;
    in_busy   = block | out_busy;
  end

endmodule

// File: rtl/fir_cfg_loader.sv
// Reloads WINLEN filter coefficients through a one-entry hold register while blocking samples.
// Latency: coefficient appears on cfg one cycle after acceptance; peak rate one per two cycles.
// Backpressure: cfg_busy stalls the hold register; coef_busy depends only on registered state.
// Optional build macro FIR_CFG_CHECKSUM_EN adds the cfg_sum checksum output.
module fir_cfg_loader
  import fir_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int WINLEN = WINLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  output logic              load_active,
  output logic              load_done,
  input  logic              coef_valid,
  output logic              coef_busy,
  input  logic [DWIDTH-1:0] coef_data,
  output logic              cfg_valid,
  input  logic              cfg_busy,
  output logic [AWIDTH-1:0] cfg_addr,
  output logic [DWIDTH-1:0] cfg_data,
`ifdef FIR_CFG_CHECKSUM_EN
  output logic [DWIDTH+AWIDTH-1:0] cfg_sum,
`endif
  input  logic              smp_in_valid,
  output logic              smp_in_busy,
  input  logic [DWIDTH-1:0] smp_in_data,
  output logic              smp_out_valid,
  input  logic              smp_out_busy,
  output logic [DWIDTH-1:0] smp_out_data
);

  // One extra bit so the counts can hold WINLEN itself without wrapping.
  localparam int CW = AWIDTH + 1;
  localparam logic [CW-1:0] WIN_CNT  = CW'(WINLEN);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINLEN - 1);

  fir_state_t        state_q, state_d;
  logic [CW-1:0]     in_cnt, out_cnt;
  logic              hold_full;
  logic [DWIDTH-1:0] hold_data;
  logic [AWIDTH-1:0] hold_addr;
  logic              coef_fire, cfg_fire, start_load, last_wr;

  // coef_busy is built from registers only; hold-full excludes a same-cycle cfg transfer.
  always_comb begin
    coef_busy  = ~((state_q == LOAD) & ~hold_full & (in_cnt < WIN_CNT));
    coef_fire  = coef_valid & ~coef_busy;
    cfg_fire   = hold_full & ~cfg_busy;
    start_load = (state_q == IDLE) & load_start;
    last_wr    = cfg_fire & (out_cnt == WIN_LAST);
    cfg_valid  = hold_full;
    cfg_addr   = hold_addr;
    cfg_data   = hold_data;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and status outputs; load_start is only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    load_active = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: begin
        load_active = 1'b1;
        if (last_wr) state_d = DONE;
      end
      DONE: begin
        load_active = 1'b1;
        load_done   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts and hold register; a coef transfer only happens with the hold empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_addr <= '0;
    end else if (start_load) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      hold_full <= 1'b0;
    end else if (coef_fire) begin
      hold_full <= 1'b1;
      hold_data <= coef_data;
      hold_addr <= in_cnt[AWIDTH-1:0];
      in_cnt    <= in_cnt + 1'b1;
    end else if (cfg_fire) begin
      hold_full <= 1'b0;
      out_cnt   <= out_cnt + 1'b1;
    end
  end

`ifdef FIR_CFG_CHECKSUM_EN
  // Unsigned running sum of every coefficient written; held after the reload ends.
  always_ff @(posedge clk) begin
    if (!rst_n)          cfg_sum <= '0;
    else if (start_load) cfg_sum <= '0;
    else if (cfg_fire)   cfg_sum <= cfg_sum + {{AWIDTH{1'b0}}, hold_data};
  end
`endif

  fir_smp_gate #(.DWIDTH(DWIDTH)) u_smp_gate (
    .block     (state_q != IDLE),
    .in_valid  (smp_in_valid),
    .in_busy   (smp_in_busy),
    .in_data   (smp_in_data),
    .out_valid (smp_out_valid),
    .out_busy  (smp_out_busy),
    .out_data  (smp_out_data)
  );

endmodule

// File: tb/tb_fir_cfg_loader.sv
// Directed bench for fir_cfg_loader with a 4-tap window.
// Latency: n/a.
// Backpressure: cfg_busy driven by the bench to create stalls.
module tb_fir_cfg_loader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic rst_n, load_start, load_active, load_done;
  logic coef_valid, coef_busy;
  logic [DW-1:0] coef_data;
  logic cfg_valid, cfg_busy;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic smp_in_valid, smp_in_busy, smp_out_valid, smp_out_busy;
  logic [DW-1:0] smp_in_data, smp_out_data;
`ifdef FIR_CFG_CHECKSUM_EN
  logic [DW+AW-1:0] cfg_sum;
`endif

  fir_cfg_loader #(.DWIDTH(DW), .AWIDTH(AW), .WINLEN(WL)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .load_active(load_active), .load_done(load_done),
    .coef_valid(coef_valid), .coef_busy(coef_busy), .coef_data(coef_data),
    .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef FIR_CFG_CHECKSUM_EN
    .cfg_sum(cfg_sum),
`endif
    .smp_in_valid(smp_in_valid), .smp_in_busy(smp_in_busy), .smp_in_data(smp_in_data),
    .smp_out_valid(smp_out_valid), .smp_out_busy(smp_out_busy), .smp_out_data(smp_out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  logic [DW-1:0] vec[4];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ob;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ib;
  } smp_vec_t;
  smp_vec_t smp_tab[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe every cfg write and every done pulse away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cfg_valid && !cfg_busy) begin
      wr_addr.push_back(int'(cfg_addr));
      wr_data.push_back(int'(cfg_data));
      wr_cyc.push_back(cyc);
    end
    if (rst_n && load_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  task automatic drive_coefs(input int n);
    int idx;
    int t;
    idx = 0;
    t = 0;
    @(posedge clk); #1;
    coef_valid = 1'b1;
    coef_data  = vec[0];
    while (idx < n && t < 200) begin
      @(negedge clk);
      if (coef_valid && !coef_busy) idx++;
      @(posedge clk); #1;
      if (idx < n) coef_data = vec[idx];
      else         coef_valid = 1'b0;
      t++;
    end
    coef_valid = 1'b0;
    if (idx < n) check("coef_drive_timeout", idx, n);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic stall_at_addr1();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(cfg_valid && !cfg_busy && cfg_addr == 0) && t < 100);
    @(posedge clk); #1 cfg_busy = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!cfg_valid && t < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_hold {vld,coef_busy,addr,data}",
            {cfg_valid, coef_busy, cfg_addr, cfg_data}, {1'b1, 1'b1, 6'd1, 8'h02});
    end
    @(posedge clk); #1 cfg_busy = 1'b0;
  endtask

  task automatic repeat_start();
    repeat (3) begin
      @(posedge clk); #1 load_start = 1'b1;
      @(posedge clk); #1 load_start = 1'b0;
    end
  endtask

  task automatic check_writes(input string tag, input logic check_rate);
    check({tag, "_wr_count"}, wr_addr.size(), WL);
    check({tag, "_done_count"}, done_cnt, 1);
    if (wr_addr.size() == WL) begin
      for (int i = 0; i < WL; i++) begin
        check({tag, "_wr_addr"}, wr_addr[i], i);
        check({tag, "_wr_data"}, wr_data[i], int'(vec[i]));
        if (check_rate && i > 0) check({tag, "_wr_spacing"}, wr_cyc[i] - wr_cyc[i-1], 2);
      end
      check({tag, "_done_after_last"}, done_cyc - wr_cyc[WL-1], 1);
    end
  endtask

  initial begin
    smp_tab[0] = '{v:1'b1, d:8'h7F, ob:1'b0, e_ov:1'b1, e_od:8'h7F, e_ib:1'b0};
    smp_tab[1] = '{v:1'b1, d:8'h7F, ob:1'b1, e_ov:1'b1, e_od:8'h7F, e_ib:1'b1};
    smp_tab[2] = '{v:1'b0, d:8'hA5, ob:1'b0, e_ov:1'b0, e_od:8'hA5, e_ib:1'b0};
    smp_tab[3] = '{v:1'b1, d:8'h3C, ob:1'b1, e_ov:1'b1, e_od:8'h3C, e_ib:1'b1};

    rst_n = 1'b0; load_start = 1'b0; coef_valid = 1'b0; coef_data = '0;
    cfg_busy = 1'b0; smp_in_valid = 1'b0; smp_in_data = '0; smp_out_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_coef_busy", coef_busy, 1);
    check("rst_load_active", load_active, 0);
    check("rst_load_done", load_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Sample pass-through in IDLE.
    for (int i = 0; i < 4; i++) begin
      smp_in_valid = smp_tab[i].v; smp_in_data = smp_tab[i].d; smp_out_busy = smp_tab[i].ob;
      #1;
      check("idle_smp_out_valid", smp_out_valid, smp_tab[i].e_ov);
      check("idle_smp_out_data", smp_out_data, smp_tab[i].e_od);
      check("idle_smp_in_busy", smp_in_busy, smp_tab[i].e_ib);
    end

    // Basic back-to-back load; sample path blocked while loading.
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03; vec[3] = 8'h04;
    clear_log();
    start_load();
    check("load_active_in_load", load_active, 1);
    for (int i = 0; i < 4; i++) begin
      smp_in_valid = smp_tab[i].v; smp_in_data = smp_tab[i].d; smp_out_busy = smp_tab[i].ob;
      #1;
      check("load_smp_out_valid", smp_out_valid, 0);
      check("load_smp_in_busy", smp_in_busy, 1);
    end
    smp_in_valid = 1'b0; smp_out_busy = 1'b0;
    drive_coefs(WL);
    wait_done();
    check_writes("basic", 1'b1);
    check("idle_after_done", load_active, 0);

    // Stall with cfg_busy while address 1 is held.
    clear_log();
    start_load();
    fork
      drive_coefs(WL);
      stall_at_addr1();
    join
    wait_done();
    check_writes("stall", 1'b0);

    // Reset after two of four writes.
    clear_log();
    start_load();
    drive_coefs(2);
    begin
      int t;
      t = 0;
      while (wr_addr.size() < 2 && t < 50) begin @(negedge clk); t++; end
    end
    check("pre_reset_writes", wr_addr.size(), 2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_load_active", load_active, 0);
    check("after_reset_cfg_valid", cfg_valid, 0);
    check("after_reset_coef_busy", coef_busy, 1);
    repeat (4) @(negedge clk);
    check("after_reset_no_done", done_cnt, 0);
    clear_log();
    start_load();
    drive_coefs(WL);
    wait_done();
    check_writes("restart", 1'b1);

    // load_start repeated while loading is ignored.
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
    clear_log();
    start_load();
    fork
      drive_coefs(WL);
      repeat_start();
    join
    wait_done();
    check_writes("repstart", 1'b1);

`ifdef FIR_CFG_CHECKSUM_EN
    vec[0] = 8'hFF; vec[1] = 8'hFF; vec[2] = 8'hFF; vec[3] = 8'hFF;
    clear_log();
    start_load();
    drive_coefs(WL);
    wait_done();
    check_writes("sum", 1'b1);
    check("cfg_sum", cfg_sum, 14'h3FC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
